// File: rtl/multi_unit_sched_pkg.sv
// Shared types and default parameters for the multi-unit scheduler.
// The state encoding is common to the top-level FSM and any debug tooling.
package multi_unit_sched_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  localparam int DEF_N       = 4;
  localparam int DEF_W       = 32;
  localparam int DEF_TIMEOUT = 16;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: grants the first requester at or after ptr,
// wrapping modulo N. Reusable outside the scheduler.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx,
  output logic          any
);

  logic [N-1:0]  rot_req;
  logic [IW-1:0] rot_pos [N];

  // rot_pos[gi] is the requester examined at priority rank gi; ptr is always < N
  for (genvar gi = 0; gi < N; gi++) begin : g_rot
    logic [IW:0] sum;
    assign sum          = {1'b0, ptr} + (IW+1)'(gi);
    assign rot_pos[gi]  = (sum >= (IW+1)'(N)) ? IW'(sum - (IW+1)'(N)) : sum[IW-1:0];
    assign rot_req[gi]  = req[rot_pos[gi]];
  end

  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (!any && rot_req[k]) begin
        any = 1'b1;
        idx = rot_pos[k];
      end
    end
    if (any) grant[idx] = 1'b1;
  end

endmodule

// File: rtl/multi_unit_sched.sv
// Serializes jobs from N requesters onto one variable-latency unit, returns each
// result to its originator, and aborts a hung unit after TIMEOUT wait cycles.
module multi_unit_sched
  import multi_unit_sched_pkg::*;
#(
  parameter int N       = DEF_N,
  parameter int W       = DEF_W,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic           clock,
  input  logic           reset,
  input  logic [N-1:0]   req_valid,
  input  logic [N*W-1:0] req_data,
  output logic [N-1:0]   req_ready,
  output logic [N-1:0]   resp_valid,
  input  logic [N-1:0]   resp_ready,
  output logic [W-1:0]   resp_data,
  output logic           resp_err,
  output logic           unit_start,
  output logic [W-1:0]   unit_inp,
  input  logic           unit_done,
  input  logic [W-1:0]   unit_out,
  output logic           unit_reset,
  output logic           busy
);

  localparam int IW = $clog2(N);
  localparam int CW = $clog2(TIMEOUT);

  state_t         state_reg, state_next;
  logic [IW-1:0]  ptr_reg, owner_reg, owner_inc;
  logic [W-1:0]   operand_reg, resp_data_reg;
  logic           resp_err_reg;
  logic [CW-1:0]  wait_cnt_reg;
  logic           timeout_pulse_reg;
  logic           wait_expire;

  logic [N-1:0]   grant;
  logic [IW-1:0]  grant_idx;
  logic           grant_any;
  logic [W-1:0]   req_word [N];

  for (genvar gi = 0; gi < N; gi++) begin : g_word
    assign req_word[gi] = req_data[gi*W +: W];
  end

  rr_arbiter #(.N(N), .IW(IW)) u_arb (
    .req   (req_valid),
    .ptr   (ptr_reg),
    .grant (grant),
    .idx   (grant_idx),
    .any   (grant_any)
  );

  // A done in the final wait cycle takes priority over the abort
  assign wait_expire = (state_reg == WAIT) && !unit_done &&
                       (wait_cnt_reg == CW'(TIMEOUT - 1));
  assign owner_inc   = (owner_reg == IW'(N - 1)) ? '0 : owner_reg + IW'(1);

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (grant_any) state_next = ISSUE;
      ISSUE:   state_next = WAIT;
      WAIT:    if (unit_done || wait_expire) state_next = RESP;
      RESP:    if (resp_ready[owner_reg]) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg         <= IDLE;
      ptr_reg           <= '0;
      owner_reg         <= '0;
      operand_reg       <= '0;
      resp_data_reg     <= '0;
      resp_err_reg      <= 1'b0;
      wait_cnt_reg      <= '0;
      timeout_pulse_reg <= 1'b0;
    end else begin
      state_reg         <= state_next;
      timeout_pulse_reg <= wait_expire;
      case (state_reg)
        IDLE: begin
          if (grant_any) begin
            operand_reg <= req_word[grant_idx];
            owner_reg   <= grant_idx;
          end
        end
        ISSUE: wait_cnt_reg <= '0;
        WAIT: begin
          if (unit_done) begin
            resp_data_reg <= unit_out;
            resp_err_reg  <= 1'b0;
          end else if (wait_expire) begin
            resp_data_reg <= '0;
            resp_err_reg  <= 1'b1;
          end else begin
            wait_cnt_reg <= wait_cnt_reg + CW'(1);
          end
        end
        RESP: if (resp_ready[owner_reg]) ptr_reg <= owner_inc;
        default: ;
      endcase
    end
  end

  // Grant is suppressed while reset is asserted so no handshake can slip through
  assign req_ready = (state_reg == IDLE && !reset) ? grant : '0;

  for (genvar gi = 0; gi < N; gi++) begin : g_resp
    assign resp_valid[gi] = (state_reg == RESP) && (owner_reg == IW'(gi));
  end

  assign resp_data  = resp_data_reg;
  assign resp_err   = resp_err_reg;
  assign unit_start = (state_reg == ISSUE);
  assign unit_inp   = operand_reg;
  assign unit_reset = reset | timeout_pulse_reg;
  assign busy       = (state_reg != IDLE);

endmodule

// File: tb/tb_multi_unit_sched.sv
// Scoreboard bench for multi_unit_sched with a behavioural variable-latency unit.
module tb_multi_unit_sched;
  localparam int N  = 4;
  localparam int W  = 32;
  localparam int TO = 16;

  logic           clock = 1'b0;
  logic           reset = 1'b1;
  logic [N-1:0]   req_valid = '0;
  logic [N*W-1:0] req_data = '0;
  logic [N-1:0]   req_ready;
  logic [N-1:0]   resp_valid;
  logic [N-1:0]   resp_ready = '0;
  logic [W-1:0]   resp_data;
  logic           resp_err;
  logic           unit_start;
  logic [W-1:0]   unit_inp;
  logic           unit_done;
  logic [W-1:0]   unit_out = '0;
  logic           unit_reset;
  logic           busy;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  int          done_delay = 1;
  logic [W-1:0] key = '0;
  logic        expect_timeout = 1'b0;
  logic        model_done = 1'b0;
  logic        inject_done = 1'b0;
  logic [W-1:0] u_inp = '0;
  int          u_cnt = 0;
  logic        u_busy = 1'b0;

  typedef struct {
    int          owner;
    logic [W-1:0] data;
    logic        err;
  } exp_t;
  exp_t sb[$];

  multi_unit_sched #(.N(N), .W(W), .TIMEOUT(TO)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_data(resp_data), .resp_err(resp_err),
    .unit_start(unit_start), .unit_inp(unit_inp),
    .unit_done(unit_done), .unit_out(unit_out),
    .unit_reset(unit_reset), .busy(busy)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc++;

  assign unit_done = model_done | inject_done;

  // Unit model: done_delay cycles after the start cycle, out = inp ^ key; 0 = never
  always @(posedge clock) begin
    if (unit_reset) begin
      model_done <= 1'b0;
      u_busy     <= 1'b0;
      u_cnt      <= 0;
    end else begin
      model_done <= 1'b0;
      if (unit_start) begin
        u_inp <= unit_inp;
        if (done_delay == 1) begin
          model_done <= 1'b1;
          unit_out   <= unit_inp ^ key;
          u_busy     <= 1'b0;
        end else begin
          u_busy <= (done_delay > 1);
          u_cnt  <= done_delay - 1;
        end
      end else if (u_busy) begin
        if (u_cnt == 1) begin
          model_done <= 1'b1;
          unit_out   <= u_inp ^ key;
          u_busy     <= 1'b0;
        end
        u_cnt <= u_cnt - 1;
      end
    end
  end

  // Scoreboard: push on request handshake, pop and compare on response handshake
  always @(negedge clock) begin
    if (!reset) begin
      if (|(req_valid & req_ready)) begin
        exp_t e;
        e.owner = 0;
        for (int j = 0; j < N; j++) if (req_valid[j] && req_ready[j]) e.owner = j;
        e.data = expect_timeout ? '0 : (req_data[e.owner*W +: W] ^ key);
        e.err  = expect_timeout;
        sb.push_back(e);
        $display("[%0d] accept requester %0d data=%h", cyc, e.owner, req_data[e.owner*W +: W]);
      end
      if (|(resp_valid & resp_ready)) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL sb_unexpected: resp_valid=%b data=%h with no job outstanding", resp_valid, resp_data);
        end else begin
          exp_t e;
          logic [N-1:0] onehot;
          e = sb.pop_front();
          onehot = '0;
          onehot[e.owner] = 1'b1;
          if (resp_valid !== onehot || resp_data !== e.data || resp_err !== e.err) begin
            errors++;
            $display("FAIL sb_resp: got valid=%b data=%h err=%b, want valid=%b data=%h err=%b",
                     resp_valid, resp_data, resp_err, onehot, e.data, e.err);
          end else begin
            $display("[%0d] resp requester %0d data=%h err=%b", cyc, e.owner, resp_data, resp_err);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_idle(input string name);
    int c;
    c = 0;
    while (busy === 1'b1 && c < 100) begin
      @(negedge clock);
      c++;
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL %s_idle: busy=%b after %0d cycles, want 0", name, busy, c);
    end
  endtask

  task automatic test_reset();
    @(negedge clock);
    checks++;
    if (req_ready !== '0 || resp_valid !== '0 || resp_data !== '0 || resp_err !== 1'b0 ||
        unit_start !== 1'b0 || unit_inp !== '0 || busy !== 1'b0 || unit_reset !== 1'b1) begin
      errors++;
      $display("FAIL reset_values: rr=%b rv=%b rd=%h re=%b us=%b ui=%h busy=%b ur=%b, want 0,0,0,0,0,0,0,1",
               req_ready, resp_valid, resp_data, resp_err, unit_start, unit_inp, busy, unit_reset);
    end
    @(posedge clock);
    #1;
    reset = 1'b0;
    @(negedge clock);
    checks++;
    if (unit_reset !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: unit_reset=%b busy=%b, want 0 0", unit_reset, busy);
    end
    $display("[%0d] reset released", cyc);
  endtask

  task automatic test_round_robin();
    int gl[$];
    int gc[$];
    key = 32'h0F0F_1234;
    done_delay = 1;
    resp_ready = '1;
    tick();
    for (int i = 0; i < N; i++) req_data[i*W +: W] = 32'h1111_0000 + i;
    req_valid = '1;
    for (int c = 0; c < 60 && gl.size() < 5; c++) begin
      @(negedge clock);
      if (|req_ready) begin
        for (int j = 0; j < N; j++) if (req_ready[j]) gl.push_back(j);
        gc.push_back(cyc);
      end
    end
    tick();
    req_valid = '0;
    checks++;
    if (gl.size() != 5) begin
      errors++;
      $display("FAIL rr_count: got %0d grants, want 5", gl.size());
    end else begin
      for (int k = 0; k < 5; k++) begin
        checks++;
        if (gl[k] != k % N) begin
          errors++;
          $display("FAIL rr_order: grant %0d went to %0d, want %0d", k, gl[k], k % N);
        end
        if (k > 0) begin
          checks++;
          if (gc[k] - gc[k-1] != 4) begin
            errors++;
            $display("FAIL rr_spacing: grant %0d spacing %0d, want 4", k, gc[k] - gc[k-1]);
          end
        end
      end
    end
    wait_idle("rr");
  endtask

  task automatic test_single();
    key = '0;
    done_delay = 1;
    resp_ready = '1;
    tick();
    req_data[1*W +: W] = 32'hDEAD_BEEF;
    req_valid = 4'b0010;
    @(negedge clock);
    checks++;
    if (req_ready !== 4'b0010) begin
      errors++;
      $display("FAIL single_ready: req_ready=%b, want 0010", req_ready);
    end
    tick();
    req_valid = '0;
    @(negedge clock);
    checks++;
    if (unit_start !== 1'b1 || unit_inp !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL single_start: unit_start=%b unit_inp=%h, want 1 deadbeef", unit_start, unit_inp);
    end
    @(negedge clock);
    checks++;
    if (busy !== 1'b1 || resp_valid !== '0 || unit_start !== 1'b0) begin
      errors++;
      $display("FAIL single_wait: busy=%b resp_valid=%b unit_start=%b, want 1 0000 0", busy, resp_valid, unit_start);
    end
    @(negedge clock);
    checks++;
    if (resp_valid !== 4'b0010 || resp_data !== 32'hDEAD_BEEF || resp_err !== 1'b0 || unit_reset !== 1'b0) begin
      errors++;
      $display("FAIL single_resp: valid=%b data=%h err=%b ureset=%b, want 0010 deadbeef 0 0",
               resp_valid, resp_data, resp_err, unit_reset);
    end
    wait_idle("single");
  endtask

  task automatic test_backpressure();
    logic [W-1:0] want;
    int c;
    key = 32'hCAFE_0000;
    done_delay = 3;
    resp_ready = 4'b1011;
    tick();
    req_data[2*W +: W] = 32'h2222_3333;
    req_valid = 4'b0100;
    want = 32'h2222_3333 ^ 32'hCAFE_0000;
    @(negedge clock);
    checks++;
    if (req_ready !== 4'b0100) begin
      errors++;
      $display("FAIL bp_ready: req_ready=%b, want 0100", req_ready);
    end
    tick();
    req_data[0*W +: W] = 32'h0000_0A0A;
    req_valid = 4'b0001;
    c = 0;
    while (resp_valid === '0 && c < 20) begin
      @(negedge clock);
      c++;
    end
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (resp_valid !== 4'b0100 || resp_data !== want || req_ready !== '0) begin
        errors++;
        $display("FAIL bp_hold: cycle %0d valid=%b data=%h req_ready=%b, want 0100 %h 0000",
                 k, resp_valid, resp_data, req_ready, want);
      end
      if (k < 4) @(negedge clock);
    end
    tick();
    resp_ready = '1;
    @(negedge clock);
    checks++;
    if (resp_valid !== 4'b0100 || req_ready !== '0) begin
      errors++;
      $display("FAIL bp_accept: valid=%b req_ready=%b, want 0100 0000", resp_valid, req_ready);
    end
    @(negedge clock);
    checks++;
    if (req_ready !== 4'b0001) begin
      errors++;
      $display("FAIL bp_next_grant: req_ready=%b, want 0001", req_ready);
    end
    tick();
    req_valid = '0;
    wait_idle("bp");
  endtask

  task automatic test_timeout();
    int pulses, pc, rc, rn;
    logic idle_late;
    pulses = 0; pc = -1; rc = -1; rn = 0; idle_late = 1'b1;
    key = 32'h0000_0001;
    done_delay = 0;
    expect_timeout = 1'b1;
    resp_ready = '1;
    tick();
    req_data[3*W +: W] = 32'h3333_4444;
    req_valid = 4'b1000;
    @(negedge clock);
    checks++;
    if (req_ready !== 4'b1000) begin
      errors++;
      $display("FAIL to_ready: req_ready=%b, want 1000", req_ready);
    end
    tick();
    req_valid = '0;
    expect_timeout = 1'b0;
    for (int k = 1; k <= 21; k++) begin
      @(negedge clock);
      if (unit_reset === 1'b1) begin pulses++; pc = k; end
      if (resp_valid !== '0) begin rn++; rc = k; end
      if (k >= 20 && busy !== 1'b0) idle_late = 1'b0;
      if (k == 19) begin tick(); inject_done = 1'b1; end
      if (k == 20) begin tick(); inject_done = 1'b0; end
    end
    checks++;
    if (pulses != 1 || pc != TO + 2) begin
      errors++;
      $display("FAIL to_unit_reset: %0d pulses at T+%0d, want 1 at T+%0d", pulses, pc, TO + 2);
    end
    checks++;
    if (rn != 1 || rc != TO + 2) begin
      errors++;
      $display("FAIL to_resp_time: %0d resp cycles at T+%0d, want 1 at T+%0d", rn, rc, TO + 2);
    end
    checks++;
    if (!idle_late) begin
      errors++;
      $display("FAIL to_late_done: busy=%b after stale done, want 0", busy);
    end
  endtask

  task automatic test_done_last();
    int pulses, rc;
    pulses = 0; rc = -1;
    key = 32'h00FF_00FF;
    done_delay = TO;
    resp_ready = '1;
    tick();
    req_data[2*W +: W] = 32'h5555_6666;
    req_valid = 4'b0100;
    @(negedge clock);
    tick();
    req_valid = '0;
    for (int k = 1; k <= 19; k++) begin
      @(negedge clock);
      if (unit_reset === 1'b1) pulses++;
      if (resp_valid !== '0 && rc < 0) rc = k;
    end
    checks++;
    if (pulses != 0 || rc != TO + 2) begin
      errors++;
      $display("FAIL last_done: unit_reset pulses=%0d resp at T+%0d, want 0 and T+%0d", pulses, rc, TO + 2);
    end
    wait_idle("last");
  endtask

  task automatic test_reset_mid();
    int rn;
    rn = 0;
    key = '0;
    done_delay = 0;
    resp_ready = '1;
    tick();
    req_data[0*W +: W] = 32'h0000_0077;
    req_valid = 4'b0001;
    @(negedge clock);
    checks++;
    if (req_ready !== 4'b0001) begin
      errors++;
      $display("FAIL mid_ready: req_ready=%b, want 0001", req_ready);
    end
    tick();
    req_valid = '0;
    repeat (4) @(posedge clock);
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (busy !== 1'b0 || unit_reset !== 1'b1 || resp_valid !== '0 || unit_start !== 1'b0 ||
        resp_data !== '0 || resp_err !== 1'b0 || unit_inp !== '0) begin
      errors++;
      $display("FAIL mid_async: busy=%b ureset=%b rv=%b us=%b rd=%h re=%b ui=%h, want 0 1 0 0 0 0 0",
               busy, unit_reset, resp_valid, unit_start, resp_data, resp_err, unit_inp);
    end
    sb.delete();
    $display("[%0d] reset asserted mid-job", cyc);
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clock);
      if (resp_valid !== '0) rn++;
    end
    checks++;
    if (rn != 0) begin
      errors++;
      $display("FAIL mid_no_resp: %0d response cycles after reset, want 0", rn);
    end
    key = 32'h1234_5678;
    done_delay = 2;
    tick();
    req_data[1*W +: W] = 32'hAAAA_0001;
    req_data[3*W +: W] = 32'hAAAA_0003;
    req_valid = 4'b1010;
    @(negedge clock);
    checks++;
    if (req_ready !== 4'b0010) begin
      errors++;
      $display("FAIL mid_ptr: req_ready=%b, want 0010 (ptr back to 0)", req_ready);
    end
    tick();
    req_valid = '0;
    wait_idle("mid");
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_single();
    test_backpressure();
    test_timeout();
    test_done_last();
    test_reset_mid();
    repeat (2) @(negedge clock);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_drain: %0d responses outstanding, want 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule
